// File: rtl/fma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fma_pkg
// Description : Shared constants, the result-selection enum and the
//               case-selection helper for the FMA mantissa sum pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package fma_pkg;

  // Deepest pipeline the sum block can be configured for.
  localparam int FMA_SUM_MAX_STAGES = 4;

  // Which rule the sum core applies to the current operand pair.
  typedef enum logic [2:0] {
    SUM_BOTH_ZERO    = 3'd0,
    SUM_ADDEND_ZERO  = 3'd1,
    SUM_PRODUCT_ZERO = 3'd2,
    SUM_EFF_ADD      = 3'd3,
    SUM_EFF_SUB      = 3'd4
  } sum_case_e;

  // Priority-ordered selection: the zero flags override the arithmetic.
  function automatic sum_case_e sum_case(input logic z_zero,
                                         input logic no_product,
                                         input logic diff_sign);
    sum_case_e sel;
    if (z_zero && no_product) sel = SUM_BOTH_ZERO;
    else if (z_zero)          sel = SUM_ADDEND_ZERO;
    else if (no_product)      sel = SUM_PRODUCT_ZERO;
    else if (!diff_sign)      sel = SUM_EFF_ADD;
    else                      sel = SUM_EFF_SUB;
    return sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fma_sum_core.sv
`default_nettype none
// ============================================================================
// Module      : fma_sum_core
// Description : Combinational signed-magnitude mantissa adder.
//   pm, am       : aligned product / addend mantissas (VEC_SIZE+1 bits)
//   diff_sign    : effective subtraction
//   no_product   : product is zero
//   z_zero       : addend is zero
//   sm           : sum magnitude
//   carry        : carry-out of an effective addition
//   swap         : addend larger in an effective subtraction (addend sign wins)
//   sum_zero     : sm is zero
// Revision    : 1.0 - initial release
// ============================================================================
module fma_sum_core
  import fma_pkg::*;
#(
  parameter int VEC_SIZE = 32
) (
  input  logic [VEC_SIZE:0] pm,
  input  logic [VEC_SIZE:0] am,
  input  logic              diff_sign,
  input  logic              no_product,
  input  logic              z_zero,
  output logic [VEC_SIZE:0] sm,
  output logic              carry,
  output logic              swap,
  output logic              sum_zero
);

  logic [VEC_SIZE+1:0] w_add_full;
  logic [VEC_SIZE:0]   w_pm_minus_am;
  logic [VEC_SIZE:0]   w_am_minus_pm;
  logic                w_am_gt_pm;
  sum_case_e           w_sel;

  // One extra bit keeps the carry of the widest possible addition.
  assign w_add_full    = {1'b0, pm} + {1'b0, am};
  assign w_pm_minus_am = pm - am;
  assign w_am_minus_pm = am - pm;
  assign w_am_gt_pm    = (am > pm);
  assign w_sel         = sum_case(z_zero, no_product, diff_sign);

  always_comb begin
    sm    = '0;
    carry = 1'b0;
    swap  = 1'b0;
    case (w_sel)
      SUM_BOTH_ZERO:    sm = '0;
      SUM_ADDEND_ZERO:  sm = pm;
      SUM_PRODUCT_ZERO: begin
        sm   = am;
        swap = diff_sign;
      end
      SUM_EFF_ADD:      {carry, sm} = w_add_full;
      SUM_EFF_SUB: begin
        // Equal operands take the pm-am path, giving zero with no swap.
        sm   = w_am_gt_pm ? w_am_minus_pm : w_pm_minus_am;
        swap = w_am_gt_pm;
      end
      default:          sm = '0;
    endcase
  end

  assign sum_zero = (sm == '0);

endmodule
`default_nettype wire

// File: rtl/fma_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fma_sum_pipe
// Description : Pipelined mantissa adder with valid/ready handshake and
//               STAGES (1..4) register slices after the combinational core.
//   clk, reset            : clock, asynchronous active-high reset
//   in_valid / in_ready   : input handshake
//   pm, am, diff_sign,
//   no_product, z_zero    : operand pair and flags
//   out_valid / out_ready : output handshake
//   sm, carry, swap,
//   sum_zero              : registered result of the final stage
// Revision    : 1.0 - initial release
// ============================================================================
module fma_sum_pipe
  import fma_pkg::*;
#(
  parameter int VEC_SIZE = 32,
  parameter int STAGES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VEC_SIZE:0] pm,
  input  logic [VEC_SIZE:0] am,
  input  logic              diff_sign,
  input  logic              no_product,
  input  logic              z_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [VEC_SIZE:0] sm,
  output logic              carry,
  output logic              swap,
  output logic              sum_zero
);

  if (STAGES < 1 || STAGES > FMA_SUM_MAX_STAGES) begin : g_bad_stages
    $error("fma_sum_pipe: STAGES must lie in 1..%0d", FMA_SUM_MAX_STAGES);
  end

  typedef struct packed {
    logic [VEC_SIZE:0] sm;
    logic              carry;
    logic              swap;
    logic              sum_zero;
  } sum_payload_t;

  sum_payload_t                w_core;
  logic [VEC_SIZE:0]           w_core_sm;
  logic                        w_core_carry;
  logic                        w_core_swap;
  logic                        w_core_zero;
  logic         [STAGES-1:0]   w_ready;
  logic         [STAGES-1:0]   w_valid;
  sum_payload_t [STAGES-1:0]   w_payload;
  sum_payload_t                w_out;

  fma_sum_core #(
    .VEC_SIZE (VEC_SIZE)
  ) u_core (
    .pm         (pm),
    .am         (am),
    .diff_sign  (diff_sign),
    .no_product (no_product),
    .z_zero     (z_zero),
    .sm         (w_core_sm),
    .carry      (w_core_carry),
    .swap       (w_core_swap),
    .sum_zero   (w_core_zero)
  );

  assign w_core = '{sm: w_core_sm, carry: w_core_carry,
                    swap: w_core_swap, sum_zero: w_core_zero};

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    logic         valid_d;
    logic         valid_q;
    sum_payload_t payload_d;
    sum_payload_t payload_q;
    logic         up_valid;
    sum_payload_t up_payload;

    if (gi == 0) begin : g_src_core
      assign up_valid   = in_valid;
      assign up_payload = w_core;
    end else begin : g_src_prev
      assign up_valid   = w_valid[gi-1];
      assign up_payload = w_payload[gi-1];
    end

    // Unrolled ready chain: a stage can move unless it and every stage
    // downstream of it are occupied while the consumer is stalled.
    assign w_ready[gi] = out_ready | ~(&w_valid[STAGES-1:gi]);

    // Valid follows upstream whenever the slice can move, so bubbles
    // collapse; payload only changes on an actual transfer.
    always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      if (w_ready[gi]) begin
        valid_d = up_valid;
        if (up_valid) begin
          payload_d = up_payload;
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        valid_q   <= 1'b0;
        payload_q <= '0;
      end else begin
        valid_q   <= valid_d;
        payload_q <= payload_d;
      end
    end

    assign w_valid[gi]   = valid_q;
    assign w_payload[gi] = payload_q;
  end

  assign w_out     = w_payload[STAGES-1];
  assign in_ready  = w_ready[0];
  assign out_valid = w_valid[STAGES-1];
  assign sm        = w_out.sm;
  assign carry     = w_out.carry;
  assign swap      = w_out.swap;
  assign sum_zero  = w_out.sum_zero;

endmodule
`default_nettype wire

// File: tb/tb_fma_sum_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fma_sum_pipe
// Description : Self-checking bench for fma_sum_pipe (VEC_SIZE=7) with three
//               instances of depth 1, 2 and 4 sharing one stimulus port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fma_sum_pipe;

  logic       clk = 1'b0;
  logic       reset;
  int         sel;
  logic       g_in_valid, g_out_ready, g_ds, g_np, g_zz;
  logic [7:0] g_pm, g_am;
  logic       g_in_ready, g_out_valid, g_carry, g_swap, g_sum_zero;
  logic [7:0] g_sm;

  logic       d1_iv, d1_or, d1_ir, d1_ov, d1_c, d1_s, d1_z;
  logic       d2_iv, d2_or, d2_ir, d2_ov, d2_c, d2_s, d2_z;
  logic       d4_iv, d4_or, d4_ir, d4_ov, d4_c, d4_s, d4_z;
  logic [7:0] d1_sm, d2_sm, d4_sm;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [10:0] exp_q[$];
  int          ts_q[$];

  always #5 clk = ~clk;

  fma_sum_pipe #(.VEC_SIZE(7), .STAGES(1)) u_dut1 (
    .clk(clk), .reset(reset), .in_valid(d1_iv), .in_ready(d1_ir),
    .pm(g_pm), .am(g_am), .diff_sign(g_ds), .no_product(g_np), .z_zero(g_zz),
    .out_valid(d1_ov), .out_ready(d1_or), .sm(d1_sm), .carry(d1_c),
    .swap(d1_s), .sum_zero(d1_z));

  fma_sum_pipe #(.VEC_SIZE(7), .STAGES(2)) u_dut2 (
    .clk(clk), .reset(reset), .in_valid(d2_iv), .in_ready(d2_ir),
    .pm(g_pm), .am(g_am), .diff_sign(g_ds), .no_product(g_np), .z_zero(g_zz),
    .out_valid(d2_ov), .out_ready(d2_or), .sm(d2_sm), .carry(d2_c),
    .swap(d2_s), .sum_zero(d2_z));

  fma_sum_pipe #(.VEC_SIZE(7), .STAGES(4)) u_dut4 (
    .clk(clk), .reset(reset), .in_valid(d4_iv), .in_ready(d4_ir),
    .pm(g_pm), .am(g_am), .diff_sign(g_ds), .no_product(g_np), .z_zero(g_zz),
    .out_valid(d4_ov), .out_ready(d4_or), .sm(d4_sm), .carry(d4_c),
    .swap(d4_s), .sum_zero(d4_z));

  // Route the shared stimulus to the selected instance; idle ones drain.
  always_comb begin
    d1_iv = g_in_valid & (sel == 1);
    d2_iv = g_in_valid & (sel == 2);
    d4_iv = g_in_valid & (sel == 4);
    d1_or = (sel == 1) ? g_out_ready : 1'b1;
    d2_or = (sel == 2) ? g_out_ready : 1'b1;
    d4_or = (sel == 4) ? g_out_ready : 1'b1;
    g_in_ready = d2_ir; g_out_valid = d2_ov; g_sm = d2_sm;
    g_carry = d2_c; g_swap = d2_s; g_sum_zero = d2_z;
    if (sel == 1) begin
      g_in_ready = d1_ir; g_out_valid = d1_ov; g_sm = d1_sm;
      g_carry = d1_c; g_swap = d1_s; g_sum_zero = d1_z;
    end else if (sel == 4) begin
      g_in_ready = d4_ir; g_out_valid = d4_ov; g_sm = d4_sm;
      g_carry = d4_c; g_swap = d4_s; g_sum_zero = d4_z;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] outs();
    return {g_sm, g_carry, g_swap, g_sum_zero};
  endfunction

  // Reference: {sm, carry, swap, sum_zero} from plain integer arithmetic.
  function automatic logic [10:0] model(input logic [7:0] pm, input logic [7:0] am,
                                        input logic ds, input logic np, input logic zz);
    int r;
    logic [7:0] s;
    logic c, w;
    c = 1'b0; w = 1'b0; s = 8'h00;
    if (zz && np) s = 8'h00;
    else if (zz) s = pm;
    else if (np) begin s = am; w = ds; end
    else if (!ds) begin
      r = int'(pm) + int'(am);
      s = r[7:0];
      c = (r > 255);
    end else begin
      r = int'(pm) - int'(am);
      if (r < 0) begin w = 1'b1; r = -r; end
      s = r[7:0];
    end
    return {s, c, w, (s == 8'h00)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single transfer through the 2-stage instance with out_ready held high.
  task automatic send_one(input string tag, input logic [7:0] pm, input logic [7:0] am,
                          input logic ds, input logic np, input logic zz,
                          input logic [10:0] exp);
    g_in_valid = 1'b1; g_pm = pm; g_am = am; g_ds = ds; g_np = np; g_zz = zz;
    #1;
    chk({tag, "_in_ready"}, 16'(g_in_ready), 16'd1);
    step();
    g_in_valid = 1'b0;
    chk({tag, "_not_yet"}, 16'(g_out_valid), 16'd0);
    step();
    chk({tag, "_valid"}, 16'(g_out_valid), 16'd1);
    chk({tag, "_result"}, 16'(outs()), 16'(exp));
    step();
  endtask

  task automatic run_stream(input int stg, input int n_items, input bit full);
    int sent, cyc, budget;
    logic [10:0] e;
    sent = 0; cyc = 0;
    budget = n_items * 8 + 50;
    exp_q.delete(); ts_q.delete();
    while ((sent < n_items || exp_q.size() != 0) && cyc < budget) begin
      if (sent < n_items) begin
        g_in_valid = full ? 1'b1 : ($urandom_range(0, 9) < 7);
        g_pm = 8'($urandom); g_am = 8'($urandom);
        g_ds = 1'($urandom_range(0, 1));
        g_np = ($urandom_range(0, 9) == 0);
        g_zz = ($urandom_range(0, 9) == 0);
      end else begin
        g_in_valid = 1'b0;
      end
      g_out_ready = full ? 1'b1 : ($urandom_range(0, 9) < 6);
      #1;
      if (full && sent < n_items) chk("sweep_full_in_ready", 16'(g_in_ready), 16'd1);
      if (g_out_valid && g_out_ready) begin
        chk("sweep_no_extra", 16'(exp_q.size() > 0), 16'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("sweep_result", 16'(outs()), 16'(e));
          if (full) chk("sweep_latency", 16'(cyc - ts_q[0]), 16'(stg));
          void'(ts_q.pop_front());
        end
      end
      if (g_in_valid && g_in_ready) begin
        exp_q.push_back(model(g_pm, g_am, g_ds, g_np, g_zz));
        ts_q.push_back(cyc);
        sent++;
      end
      step();
      cyc++;
    end
    chk("sweep_within_budget", 16'(cyc < budget), 16'd1);
    g_in_valid = 1'b0;
    g_out_ready = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_rdy[16];
    int exp_ov[16];
    int n_sent, n_got;
    bit stall_prev;
    logic [7:0] held_sm;
    exp_rdy = '{1,1,0,0,0,0,0,1,1,1,1,1,1,1,1,1};
    exp_ov  = '{0,0,1,1,1,1,1,1,1,1,1,1,1,0,0,0};

    reset = 1'b1; sel = 2;
    g_in_valid = 1'b0; g_out_ready = 1'b1;
    g_pm = 8'h00; g_am = 8'h00; g_ds = 1'b0; g_np = 1'b0; g_zz = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", 16'(g_out_valid), 16'd0);
    chk("rst_payload", 16'(outs()), 16'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    step();
    chk("rst_in_ready", 16'(g_in_ready), 16'd1);
    chk("rst_idle", 16'(g_out_valid), 16'd0);

    // Directed arithmetic through the 2-stage instance
    send_one("add_carry",   8'hC0, 8'h50, 1'b0, 1'b0, 1'b0, {8'h10, 3'b100});
    send_one("add_nocarry", 8'h12, 8'h34, 1'b0, 1'b0, 1'b0, {8'h46, 3'b000});
    send_one("add_max",     8'hFF, 8'hFF, 1'b0, 1'b0, 1'b0, {8'hFE, 3'b100});
    send_one("sub_swap",    8'h20, 8'h30, 1'b1, 1'b0, 1'b0, {8'h10, 3'b010});
    send_one("sub_noswap",  8'h90, 8'h25, 1'b1, 1'b0, 1'b0, {8'h6B, 3'b000});
    send_one("sub_equal",   8'h44, 8'h44, 1'b1, 1'b0, 1'b0, {8'h00, 3'b001});
    send_one("z_zero",      8'h81, 8'h12, 1'b1, 1'b0, 1'b1, {8'h81, 3'b000});
    send_one("no_prod_sub", 8'h55, 8'h3C, 1'b1, 1'b1, 1'b0, {8'h3C, 3'b010});
    send_one("no_prod_add", 8'h55, 8'h3C, 1'b0, 1'b1, 1'b0, {8'h3C, 3'b000});
    send_one("both_zero",   8'h7F, 8'h22, 1'b1, 1'b1, 1'b1, {8'h00, 3'b001});

    // Backpressure: six back-to-back items, consumer stalled in cycles 3..7
    n_sent = 0; n_got = 0; stall_prev = 1'b0; held_sm = 8'h00;
    for (int c = 1; c <= 16; c++) begin
      g_out_ready = !(c >= 3 && c <= 7);
      if (n_sent < 6) begin
        g_in_valid = 1'b1; g_pm = 8'(n_sent * 16 + 1); g_am = 8'h01;
        g_ds = 1'b0; g_np = 1'b0; g_zz = 1'b0;
      end else begin
        g_in_valid = 1'b0;
      end
      #1;
      chk("bp_in_ready", 16'(g_in_ready), 16'(exp_rdy[c-1]));
      chk("bp_out_valid", 16'(g_out_valid), 16'(exp_ov[c-1]));
      if (stall_prev) chk("bp_stable", 16'(g_sm), 16'(held_sm));
      if (g_out_valid && g_out_ready) begin
        chk("bp_order", 16'(g_sm), 16'(n_got * 16 + 2));
        n_got++;
      end
      stall_prev = g_out_valid && !g_out_ready;
      held_sm = g_sm;
      if (g_in_valid && g_in_ready) n_sent++;
      step();
    end
    chk("bp_sent", 16'(n_sent), 16'd6);
    chk("bp_received", 16'(n_got), 16'd6);

    // Reset with two results in flight
    g_out_ready = 1'b0;
    g_in_valid = 1'b1; g_pm = 8'h11; g_am = 8'h22; g_ds = 1'b0;
    step();
    g_pm = 8'h40; g_am = 8'h05;
    step();
    g_in_valid = 1'b0;
    chk("mid_inflight", 16'(g_out_valid), 16'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_valid", 16'(g_out_valid), 16'd0);
    chk("mid_rst_payload", 16'(outs()), 16'd0);
    step();
    reset = 1'b0;
    g_out_ready = 1'b1;
    #1;
    chk("mid_rel_in_ready", 16'(g_in_ready), 16'd1);
    for (int k = 0; k < 5; k++) begin
      step();
      chk("mid_no_stale", 16'(g_out_valid), 16'd0);
    end

    // Depth sweep
    sel = 1;
    run_stream(1, 1000, 1'b0);
    run_stream(1, 40, 1'b1);
    sel = 4;
    run_stream(4, 1000, 1'b0);
    run_stream(4, 40, 1'b1);
    sel = 2;
    run_stream(2, 200, 1'b0);
    run_stream(2, 40, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
